mtimer: RTL and testbench

MTIMER -- requirements
Module: mtimer

---
 rtl/mtimer_if.sv | 16 +
 rtl/mtimer.sv | 79 +++++++
 tb/tb_mtimer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mtimer_if.sv
// Bus port of the machine timer: single-cycle request, fixed one-cycle response.
interface mtimer_if;
   // req is a one-cycle strobe that is always accepted, and no ready signal exists.
   // Exactly one cycle later, ack pulses for one cycle. rdata and err are meaningful
   // only while ack is high, and rdata is forced to zero otherwise.
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (output req, we, addr, wdata, input rdata, ack, err);
   modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, msip, and a register bus.
module mtimer #(
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned HART_ID  = 0
) (
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_halt,
   mtimer_if.slave bus,
   output logic    o_tip,
   output logic    o_sip
);
   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [15:0] presc;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic        tick;
   logic        addr_ok;
   logic        wr;
   logic        wr_mtime;
   logic [31:0] rd_mux;
   logic        unused_hart;

   assign unused_hart = ^32'(HART_ID);

   assign tick     = !i_halt && (presc == PS_LAST);
   assign addr_ok  = (bus.addr[1:0] == 2'b00) && (bus.addr <= 5'h10);
   assign wr       = bus.req && bus.we && addr_ok;
   // Offsets 0x00 and 0x04 are the two halves of mtime.
   assign wr_mtime = wr && (bus.addr[4:3] == 2'b00);

   always_comb begin
      rd_mux = '0;
      case (bus.addr[4:2])
         3'd0:    rd_mux = mtime[31:0];
         3'd1:    rd_mux = mtime[63:32];
         3'd2:    rd_mux = mtimecmp[31:0];
         3'd3:    rd_mux = mtimecmp[63:32];
         3'd4:    rd_mux = {31'b0, msip};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         presc     <= '0;
         mtime     <= '0;
         mtimecmp  <= '1;
         msip      <= 1'b0;
         o_tip     <= 1'b0;
         bus.ack   <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         if (!i_halt) presc <= tick ? 16'd0 : presc + 16'd1;

         // A software write to either half suppresses the tick for the whole 64 bits.
         if (wr_mtime) begin
            if (bus.addr[2]) mtime[63:32] <= bus.wdata;
            else             mtime[31:0]  <= bus.wdata;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         if (wr && bus.addr[4:2] == 3'd2) mtimecmp[31:0]  <= bus.wdata;
         if (wr && bus.addr[4:2] == 3'd3) mtimecmp[63:32] <= bus.wdata;
         if (wr && bus.addr[4:2] == 3'd4) msip            <= bus.wdata[0];

         o_tip     <= (mtime >= mtimecmp);
         bus.ack   <= bus.req;
         bus.err   <= bus.req && !addr_ok;
         bus.rdata <= (bus.req && !bus.we && addr_ok) ? rd_mux : 32'd0;
      end
   end

   assign o_sip = msip;
endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: PRESCALE=1 and PRESCALE=4 instances share stimulus, each with its own reference model.
module tb_mtimer;
   logic        clk = 1'b0;
   logic        rst, halt, req, we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        tip1, sip1, tip4, sip4;
   logic        mon_en = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;

   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic [31:0] last_rd0;
   logic        last_err0;

   logic [63:0] m_time[2];
   logic [63:0] m_cmp[2];
   logic        m_msip[2];
   logic        m_tip[2];
   int unsigned m_run[2];

   mtimer_if bus1 ();
   mtimer_if bus4 ();

   assign bus1.req = req;  assign bus1.we = we;  assign bus1.addr = addr;  assign bus1.wdata = wdata;
   assign bus4.req = req;  assign bus4.we = we;  assign bus4.addr = addr;  assign bus4.wdata = wdata;

   mtimer #(.PRESCALE(1), .HART_ID(0)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_halt(halt), .bus(bus1), .o_tip(tip1), .o_sip(sip1));
   mtimer #(.PRESCALE(4), .HART_ID(1)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_halt(halt), .bus(bus4), .o_tip(tip4), .o_sip(sip4));

   always #5 clk = ~clk;

   function automatic int unsigned ps(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   // Reference model: one step per rising edge, from the register-level rules.
   always @(posedge clk) begin
      logic        ok;
      logic        tk;
      logic        nt;
      logic        mt_wr;
      logic [31:0] rv;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = '1;
            m_msip[k] = 1'b0;
            m_tip[k]  = 1'b0;
            m_run[k]  = 0;
         end else begin
            ok = (addr[1:0] == 2'b00) && (addr <= 5'h10);
            case (addr)
               5'h00:   rv = m_time[k][31:0];
               5'h04:   rv = m_time[k][63:32];
               5'h08:   rv = m_cmp[k][31:0];
               5'h0C:   rv = m_cmp[k][63:32];
               5'h10:   rv = {31'b0, m_msip[k]};
               default: rv = 32'd0;
            endcase
            if (req) begin
               if (k == 0) exp_q0.push_back({!ok, (ok && !we) ? rv : 32'd0});
               else        exp_q1.push_back({!ok, (ok && !we) ? rv : 32'd0});
            end
            nt = (m_time[k] >= m_cmp[k]);
            tk = !halt && ((m_run[k] % ps(k)) == ps(k) - 1);
            if (!halt) m_run[k]++;
            mt_wr = req && we && ok && (addr == 5'h00 || addr == 5'h04);
            if (req && we && ok) begin
               case (addr)
                  5'h00:   m_time[k][31:0]  = wdata;
                  5'h04:   m_time[k][63:32] = wdata;
                  5'h08:   m_cmp[k][31:0]   = wdata;
                  5'h0C:   m_cmp[k][63:32]  = wdata;
                  5'h10:   m_msip[k]        = wdata[0];
                  default: ;
               endcase
            end
            if (!mt_wr && tk) m_time[k] = m_time[k] + 64'd1;
            m_tip[k] = nt;
         end
      end
   end

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input int k, input logic ack, input logic err,
                            input logic [31:0] rdata, input logic tip, input logic sip);
      logic [32:0] e;
      string       tag;
      int          pending;
      tag = (k == 0) ? "p1" : "p4";
      if (ack) begin
         pending = (k == 0) ? exp_q0.size() : exp_q1.size();
         if (pending == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_ack_unexpected: got ack=1 expected ack=0 (no request)", tag);
         end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            cmp({tag, "_rsp_err_rdata"}, {31'b0, err, rdata}, {31'b0, e});
         end
      end else begin
         cmp({tag, "_idle_rdata"}, {32'b0, rdata}, 64'd0);
      end
      pending = (k == 0) ? exp_q0.size() : exp_q1.size();
      if (pending != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_ack_missing: got ack=0 expected ack=1", tag);
         if (k == 0) exp_q0.delete();
         else        exp_q1.delete();
      end
      cmp({tag, "_tip"}, {63'b0, tip}, {63'b0, m_tip[k]});
      cmp({tag, "_sip"}, {63'b0, sip}, {63'b0, m_msip[k]});
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus1.ack) begin
            last_rd0  = bus1.rdata;
            last_err0 = bus1.err;
         end
         check_out(0, bus1.ack, bus1.err, bus1.rdata, tip1, sip1);
         check_out(1, bus4.ack, bus4.err, bus4.rdata, tip4, sip4);
      end
   end

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic acc(input logic w, input logic [4:0] a, input logic [31:0] d);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Read one register, then let the monitor capture the response before checking it.
   task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      acc(1'b0, a, 32'd0);
      idle(1);
      cmp(name, {32'b0, last_rd0}, {32'b0, exp});
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      @(posedge clk);
      #1 mon_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Free-running count from reset.
      idle(10);
      acc(1'b0, 5'h00, 32'd0);
      idle(1);
      cmp("p1_mtime_lo_after_10", {63'b0, (last_rd0 >= 32'd9 && last_rd0 <= 32'd11)}, 64'd1);

      // Compare threshold, rise, then clear.
      acc(1'b1, 5'h0C, 32'd0);
      acc(1'b1, 5'h08, 32'd20);
      idle(25);
      acc(1'b1, 5'h08, 32'hFFFF_FFFF);
      idle(3);

      // Carry from low into high half.
      acc(1'b1, 5'h04, 32'd0);
      acc(1'b1, 5'h00, 32'hFFFF_FFFE);
      idle(2);
      halt = 1'b1;
      rd_check("p1_carry_hi", 5'h04, 32'd1);
      rd_check("p1_carry_lo", 5'h00, 32'd0);
      halt = 1'b0;

      // 64-bit wrap.
      acc(1'b1, 5'h04, 32'hFFFF_FFFF);
      acc(1'b1, 5'h00, 32'hFFFF_FFFF);
      idle(1);
      halt = 1'b1;
      rd_check("p1_wrap_lo", 5'h00, 32'd0);
      rd_check("p1_wrap_hi", 5'h04, 32'd0);
      halt = 1'b0;

      // Halt pulse, then back-to-back mtime_lo writes so one lands on a tick.
      idle(2);
      halt = 1'b1;
      idle(3);
      halt = 1'b0;
      idle(5);
      for (int i = 0; i < 5; i++) acc(1'b1, 5'h00, 32'h100 + i);
      idle(6);

      // Error accesses, then msip.
      acc(1'b0, 5'h02, 32'd0);
      idle(1);
      cmp("p1_err_misaligned", {32'b0, last_err0, last_rd0[30:0]}, {32'b0, 1'b1, 31'd0});
      acc(1'b1, 5'h14, 32'hDEAD_BEEF);
      idle(1);
      cmp("p1_err_out_of_range", {63'b0, last_err0}, 64'd1);
      rd_check("p1_cmp_lo_kept", 5'h08, 32'hFFFF_FFFF);
      acc(1'b1, 5'h10, 32'hFFFF_FFFF);
      rd_check("p1_msip_read", 5'h10, 32'd1);

      // Reset colliding with a write.
      idle(4);
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 5'h08; wdata = 32'd5;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      rd_check("p1_cmp_lo_after_rst", 5'h08, 32'hFFFF_FFFF);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         halt = ($urandom_range(0, 7) == 0);
         req  = $urandom_range(0, 1);
         we   = $urandom_range(0, 1);
         if ($urandom_range(0, 3) != 0) addr = 5'($urandom_range(0, 4) * 4);
         else                           addr = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       wdata = $urandom_range(0, 64);
            1:       wdata = 32'hFFFF_FFFF - $urandom_range(0, 64);
            2:       wdata = $urandom;
            default: wdata = 32'd0;
         endcase
         @(negedge clk);
      end
      rst = 1'b0;
      halt = 1'b0;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
